ex_stage: RTL and testbench

- Execute stage; consumes the ID/EX pipeline register outputs (aluop, alusel, operands, destination, write enable).
- Produces the write-back triple for the EX/MEM register and a HI/LO write port.
- Single-cycle logic, shift, move and add/sub ops are combinational.
- DIV/DIVU run in an iterative 32-step divider. ex_stage raises stallreq to the pipeline controller until the quotient is ready.

---
 rtl/ex_stage_pkg.sv | 55 +++++
 rtl/ex_stage_div.sv | 111 +++++++++++
 rtl/ex_stage.sv | 138 +++++++++++++
 tb/tb_ex_stage.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/ex_stage_pkg.sv
// Shared encodings for the execute stage: opcode/class buses, pipeline constants
// and the divider state type.
package ex_stage_pkg;

  typedef logic [7:0]  AluOpBus;
  typedef logic [2:0]  AluSelBus;
  typedef logic [31:0] RegBus;
  typedef logic [4:0]  RegAddrBus;

  localparam RegBus     ZeroWord     = 32'h0000_0000;
  localparam RegAddrBus NOPRegAddr   = 5'b00000;
  localparam logic      WriteEnable  = 1'b1;
  localparam logic      WriteDisable = 1'b0;
  localparam logic      Stop         = 1'b1;
  localparam logic      NoStop       = 1'b0;

  localparam AluOpBus EXE_NOP_OP  = 8'b0000_0000;
  localparam AluOpBus EXE_AND_OP  = 8'b0010_0100;
  localparam AluOpBus EXE_OR_OP   = 8'b0010_0101;
  localparam AluOpBus EXE_XOR_OP  = 8'b0010_0110;
  localparam AluOpBus EXE_NOR_OP  = 8'b0010_0111;
  localparam AluOpBus EXE_SLL_OP  = 8'b0111_1100;
  localparam AluOpBus EXE_SRL_OP  = 8'b0000_0010;
  localparam AluOpBus EXE_SRA_OP  = 8'b0000_0011;
  localparam AluOpBus EXE_MFHI_OP = 8'b0001_0000;
  localparam AluOpBus EXE_MTHI_OP = 8'b0001_0001;
  localparam AluOpBus EXE_MFLO_OP = 8'b0001_0010;
  localparam AluOpBus EXE_MTLO_OP = 8'b0001_0011;
  localparam AluOpBus EXE_ADD_OP  = 8'b0010_0000;
  localparam AluOpBus EXE_ADDU_OP = 8'b0010_0001;
  localparam AluOpBus EXE_SUB_OP  = 8'b0010_0010;
  localparam AluOpBus EXE_SUBU_OP = 8'b0010_0011;
  localparam AluOpBus EXE_SLT_OP  = 8'b0010_1010;
  localparam AluOpBus EXE_SLTU_OP = 8'b0010_1011;
  localparam AluOpBus EXE_DIV_OP  = 8'b0001_1010;
  localparam AluOpBus EXE_DIVU_OP = 8'b0001_1011;

  localparam AluSelBus EXE_RES_NOP        = 3'b000;
  localparam AluSelBus EXE_RES_LOGIC      = 3'b001;
  localparam AluSelBus EXE_RES_SHIFT      = 3'b010;
  localparam AluSelBus EXE_RES_MOVE       = 3'b011;
  localparam AluSelBus EXE_RES_ARITHMETIC = 3'b100;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

  function automatic logic is_div_op(input AluOpBus op);
    return (op == EXE_DIV_OP) || (op == EXE_DIVU_OP);
  endfunction

endpackage

// File: rtl/ex_stage_div.sv
// Iterative restoring divider: one quotient bit per cycle, signs stripped on entry
// and restored on the DONE cycle. result_o = {remainder, quotient}.
//
// state     | meaning
// DivFree   | idle, waiting for a divide opcode
// DivByZero | zero divisor, forces a 0/0 result
// DivOn     | shift-subtract iterations in progress
// DivEnd    | result valid for exactly one cycle
module div_unit
  import ex_stage_pkg::*;
#(
  parameter int DIV_STEPS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        signed_div_i,
  input  RegBus       op1_i,
  input  RegBus       op2_i,
  output logic [63:0] result_o,
  output logic        ready_o
);

  localparam int CntW = $clog2(DIV_STEPS + 1);

  div_state_e     state_q;
  logic [CntW-1:0] cnt_q;
  RegBus          rem_q;
  RegBus          quot_q;
  RegBus          dvs_q;
  logic           quot_neg_q;
  logic           rem_neg_q;

  RegBus       op1_abs;
  RegBus       op2_abs;
  logic [32:0] part_rem;
  logic [32:0] trial;
  RegBus       quot_fix;
  RegBus       rem_fix;

  // 0x80000000 negates to itself, which is exactly its magnitude read unsigned.
  always_comb begin
    op1_abs  = (signed_div_i && op1_i[31]) ? (~op1_i + 32'd1) : op1_i;
    op2_abs  = (signed_div_i && op2_i[31]) ? (~op2_i + 32'd1) : op2_i;
    part_rem = {rem_q, quot_q[31]};
    trial    = part_rem - {1'b0, dvs_q};
    quot_fix = quot_neg_q ? (~quot_q + 32'd1) : quot_q;
    rem_fix  = rem_neg_q ? (~rem_q + 32'd1) : rem_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= DivFree;
      cnt_q      <= '0;
      rem_q      <= ZeroWord;
      quot_q     <= ZeroWord;
      dvs_q      <= ZeroWord;
      quot_neg_q <= 1'b0;
      rem_neg_q  <= 1'b0;
    end else begin
      case (state_q)
        DivFree: begin
          if (start_i) begin
            if (op2_i == ZeroWord) begin
              state_q <= DivByZero;
            end else begin
              state_q    <= DivOn;
              cnt_q      <= '0;
              rem_q      <= ZeroWord;
              quot_q     <= op1_abs;
              dvs_q      <= op2_abs;
              quot_neg_q <= signed_div_i & (op1_i[31] ^ op2_i[31]);
              rem_neg_q  <= signed_div_i & op1_i[31];
            end
          end
        end
        DivByZero: begin
          rem_q      <= ZeroWord;
          quot_q     <= ZeroWord;
          quot_neg_q <= 1'b0;
          rem_neg_q  <= 1'b0;
          state_q    <= DivEnd;
        end
        DivOn: begin
          // trial[32] set means the subtraction borrowed: restore.
          if (trial[32]) begin
            rem_q  <= part_rem[31:0];
            quot_q <= {quot_q[30:0], 1'b0};
          end else begin
            rem_q  <= trial[31:0];
            quot_q <= {quot_q[30:0], 1'b1};
          end
          cnt_q <= cnt_q + CntW'(1);
          if (cnt_q == CntW'(DIV_STEPS - 1)) begin
            state_q <= DivEnd;
          end
        end
        DivEnd: begin
          state_q <= DivFree;
        end
        default: begin
          state_q <= DivFree;
        end
      endcase
    end
  end

  assign ready_o  = (state_q == DivEnd);
  assign result_o = ready_o ? {rem_fix, quot_fix} : 64'd0;

endmodule

// File: rtl/ex_stage.sv
// Execute stage: combinational ALU for single-cycle classes, HI/LO write port,
// and a stall request held while the iterative divider is working.
module ex_stage
  import ex_stage_pkg::*;
#(
  parameter int DIV_STEPS = 32
) (
  input  logic      clk,
  input  logic      rst,
  input  AluOpBus   aluop_i,
  input  AluSelBus  alusel_i,
  input  RegBus     reg1_i,
  input  RegBus     reg2_i,
  input  RegAddrBus wd_i,
  input  logic      wreg_i,
  input  RegBus     hi_i,
  input  RegBus     lo_i,
  output RegAddrBus wd_o,
  output logic      wreg_o,
  output RegBus     wdata_o,
  output logic      whilo_o,
  output RegBus     hi_o,
  output RegBus     lo_o,
  output logic      stallreq_o
);

  logic        is_div;
  logic        div_ready;
  logic [63:0] div_result;

  RegBus logic_res;
  RegBus shift_res;
  RegBus move_res;
  RegBus arith_res;
  RegBus sum;
  RegBus diff;
  logic  ov_add;
  logic  ov_sub;
  logic  ov;

  assign is_div = is_div_op(aluop_i);

  div_unit #(
    .DIV_STEPS(DIV_STEPS)
  ) u_div (
    .clk         (clk),
    .rst         (rst),
    .start_i     (is_div),
    .signed_div_i(aluop_i == EXE_DIV_OP),
    .op1_i       (reg1_i),
    .op2_i       (reg2_i),
    .result_o    (div_result),
    .ready_o     (div_ready)
  );

  always_comb begin
    sum    = reg1_i + reg2_i;
    diff   = reg1_i - reg2_i;
    ov_add = (reg1_i[31] == reg2_i[31]) && (sum[31] != reg1_i[31]);
    ov_sub = (reg1_i[31] != reg2_i[31]) && (diff[31] != reg1_i[31]);
    ov     = ((aluop_i == EXE_ADD_OP) && ov_add) || ((aluop_i == EXE_SUB_OP) && ov_sub);

    case (aluop_i)
      EXE_AND_OP: logic_res = reg1_i & reg2_i;
      EXE_OR_OP:  logic_res = reg1_i | reg2_i;
      EXE_XOR_OP: logic_res = reg1_i ^ reg2_i;
      EXE_NOR_OP: logic_res = ~(reg1_i | reg2_i);
      default:    logic_res = ZeroWord;
    endcase

    case (aluop_i)
      EXE_SLL_OP: shift_res = reg2_i << reg1_i[4:0];
      EXE_SRL_OP: shift_res = reg2_i >> reg1_i[4:0];
      EXE_SRA_OP: shift_res = RegBus'($signed(reg2_i) >>> reg1_i[4:0]);
      default:    shift_res = ZeroWord;
    endcase

    case (aluop_i)
      EXE_ADD_OP, EXE_ADDU_OP: arith_res = sum;
      EXE_SUB_OP, EXE_SUBU_OP: arith_res = diff;
      EXE_SLT_OP:  arith_res = {31'd0, $signed(reg1_i) < $signed(reg2_i)};
      EXE_SLTU_OP: arith_res = {31'd0, reg1_i < reg2_i};
      default:     arith_res = ZeroWord;
    endcase

    case (aluop_i)
      EXE_MFHI_OP: move_res = hi_i;
      EXE_MFLO_OP: move_res = lo_i;
      default:     move_res = ZeroWord;
    endcase
  end

  always_comb begin
    wd_o       = wd_i;
    wreg_o     = ov ? WriteDisable : wreg_i;
    wdata_o    = ZeroWord;
    whilo_o    = 1'b0;
    hi_o       = ZeroWord;
    lo_o       = ZeroWord;
    stallreq_o = (is_div && !div_ready) ? Stop : NoStop;

    case (alusel_i)
      EXE_RES_LOGIC:      wdata_o = logic_res;
      EXE_RES_SHIFT:      wdata_o = shift_res;
      EXE_RES_MOVE:       wdata_o = move_res;
      EXE_RES_ARITHMETIC: wdata_o = arith_res;
      default: begin
        wdata_o = ZeroWord;
        wreg_o  = WriteDisable;
      end
    endcase

    if (div_ready) begin
      whilo_o     = 1'b1;
      {hi_o, lo_o} = div_result;
    end else if (aluop_i == EXE_MTHI_OP) begin
      whilo_o = 1'b1;
      hi_o    = reg1_i;
      lo_o    = lo_i;
    end else if (aluop_i == EXE_MTLO_OP) begin
      whilo_o = 1'b1;
      hi_o    = hi_i;
      lo_o    = reg1_i;
    end

    // Reset silences every output, including the pass-through fields.
    if (!rst) begin
      wd_o       = NOPRegAddr;
      wreg_o     = WriteDisable;
      wdata_o    = ZeroWord;
      whilo_o    = 1'b0;
      hi_o       = ZeroWord;
      lo_o       = ZeroWord;
      stallreq_o = NoStop;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: vector table for single-cycle ops, hand sequences
// for divide latency, back-to-back divides and reset mid-divide.
module tb_ex_stage;
  import ex_stage_pkg::*;

  logic      clk;
  logic      rst;
  AluOpBus   aluop;
  AluSelBus  alusel;
  RegBus     reg1, reg2, hi_in, lo_in;
  RegAddrBus wd;
  logic      wreg;
  RegAddrBus wd_o;
  logic      wreg_o, whilo_o, stallreq_o;
  RegBus     wdata_o, hi_o, lo_o;

  int n_cmp = 0;
  int n_bad = 0;

  ex_stage #(.DIV_STEPS(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .aluop_i   (aluop),
    .alusel_i  (alusel),
    .reg1_i    (reg1),
    .reg2_i    (reg2),
    .wd_i      (wd),
    .wreg_i    (wreg),
    .hi_i      (hi_in),
    .lo_i      (lo_in),
    .wd_o      (wd_o),
    .wreg_o    (wreg_o),
    .wdata_o   (wdata_o),
    .whilo_o   (whilo_o),
    .hi_o      (hi_o),
    .lo_o      (lo_o),
    .stallreq_o(stallreq_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string        name;
    AluOpBus      op;
    AluSelBus     sel;
    RegBus        r1;
    RegBus        r2;
    RegAddrBus    wd;
    logic         wreg;
    RegBus        hi;
    RegBus        lo;
    logic [103:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [103:0] outs(input logic [4:0] w_d, input logic w_reg,
                                        input logic [31:0] w_data, input logic w_hilo,
                                        input logic [31:0] h, input logic [31:0] l,
                                        input logic stall);
    return {w_d, w_reg, w_data, w_hilo, h, l, stall};
  endfunction

  function automatic logic [103:0] actual();
    return {wd_o, wreg_o, wdata_o, whilo_o, hi_o, lo_o, stallreq_o};
  endfunction

  function automatic vec_t mk(input string nm, input AluOpBus op, input AluSelBus sel,
                              input RegBus r1, input RegBus r2, input RegAddrBus d,
                              input logic we, input RegBus h, input RegBus l,
                              input logic [103:0] e);
    vec_t v;
    v.name = nm; v.op = op; v.sel = sel; v.r1 = r1; v.r2 = r2;
    v.wd = d; v.wreg = we; v.hi = h; v.lo = l; v.exp = e;
    return v;
  endfunction

  task automatic check(input string nm, input logic [103:0] act, input logic [103:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input AluOpBus op, input AluSelBus sel, input RegBus r1,
                       input RegBus r2, input RegAddrBus d, input logic we,
                       input RegBus h, input RegBus l);
    aluop = op; alusel = sel; reg1 = r1; reg2 = r2;
    wd = d; wreg = we; hi_in = h; lo_in = l;
  endtask

  // Starts and ends just after a rising edge; inputs held for the whole divide.
  task automatic run_div(input string nm, input AluOpBus op, input RegBus a, input RegBus b,
                         input RegBus exp_hi, input RegBus exp_lo, input int exp_lat);
    int   lat;
    logic stall_bad;
    logic [64:0] res;
    lat = 0;
    stall_bad = 1'b0;
    res = '0;
    drive(op, EXE_RES_NOP, a, b, 5'd0, 1'b0, 32'h0, 32'h0);
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (whilo_o === 1'b1) begin
        lat = k;
        res = {stallreq_o, hi_o, lo_o};
        break;
      end else if (stallreq_o !== 1'b1) begin
        stall_bad = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    if (lat == 0) $display("FAIL %s_timeout: got no whilo pulse expected one within 60 cycles", nm);
    check({nm, "_latency"}, 104'(lat), 104'(exp_lat));
    check({nm, "_stall_hold"}, 104'(stall_bad), 104'd0);
    check({nm, "_result"}, 104'(res), 104'({1'b0, exp_hi, exp_lo}));
    tick();
  endtask

  task automatic nop_check(input string nm);
    drive(EXE_NOP_OP, EXE_RES_NOP, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    check(nm, actual(), outs(5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0));
    tick();
  endtask

  initial begin
    vecs.push_back(mk("addu_wrap", EXE_ADDU_OP, EXE_RES_ARITHMETIC, 32'hFFFFFFFF, 32'h1, 5'd5, 1'b1, 0, 0,
                      outs(5'd5, 1'b1, 32'h0, 1'b0, 0, 0, 1'b0)));
    vecs.push_back(mk("add_ovf", EXE_ADD_OP, EXE_RES_ARITHMETIC, 32'h7FFFFFFF, 32'h1, 5'd3, 1'b1, 0, 0,
                      outs(5'd3, 1'b0, 32'h80000000, 1'b0, 0, 0, 1'b0)));
    vecs.push_back(mk("add_mixed", EXE_ADD_OP, EXE_RES_ARITHMETIC, 32'h5, 32'hFFFFFFFD, 5'd4, 1'b1, 0, 0,
                      outs(5'd4, 1'b1, 32'h2, 1'b0, 0, 0, 1'b0)));
    vecs.push_back(mk("sub_ovf_neg", EXE_SUB_OP, EXE_RES_ARITHMETIC, 32'h80000000, 32'h1, 5'd6, 1'b1, 0, 0,
                      outs(5'd6, 1'b0, 32'h7FFFFFFF, 1'b0, 0, 0, 1'b0)));
    vecs.push_back(mk("sub_ovf_min", EXE_SUB_OP, EXE_RES_ARITHMETIC, 32'h0, 32'h80000000, 5'd7, 1'b1, 0, 0,
                      outs(5'd7, 1'b0, 32'h80000000, 1'b0, 0, 0, 1'b0)));
    vecs.push_back(mk("subu_wrap", EXE_SUBU_OP, EXE_RES_ARITHMETIC, 32'h5, 32'h7, 5'd8, 1'b1, 0, 0,
                      outs(5'd8, 1'b1, 32'hFFFFFFFE, 1'b0, 0, 0, 1'b0)));
    vecs.push_back(mk("slt", EXE_SLT_OP, EXE_RES_ARITHMETIC, 32'hFFFFFFFF, 32'h1, 5'd9, 1'b1, 0, 0,
                      outs(5'd9, 1'b1, 32'h1, 1'b0, 0, 0, 1'b0)));
    vecs.push_back(mk("sltu", EXE_SLTU_OP, EXE_RES_ARITHMETIC, 32'hFFFFFFFF, 32'h1, 5'd9, 1'b1, 0, 0,
                      outs(5'd9, 1'b1, 32'h0, 1'b0, 0, 0, 1'b0)));
    vecs.push_back(mk("sra_fill", EXE_SRA_OP, EXE_RES_SHIFT, 32'h4, 32'h80000000, 5'd10, 1'b1, 0, 0,
                      outs(5'd10, 1'b1, 32'hF8000000, 1'b0, 0, 0, 1'b0)));
    vecs.push_back(mk("sll", EXE_SLL_OP, EXE_RES_SHIFT, 32'h8, 32'h00000012, 5'd11, 1'b1, 0, 0,
                      outs(5'd11, 1'b1, 32'h00001200, 1'b0, 0, 0, 1'b0)));
    vecs.push_back(mk("srl_31", EXE_SRL_OP, EXE_RES_SHIFT, 32'hFFFFFFFF, 32'h80000000, 5'd12, 1'b1, 0, 0,
                      outs(5'd12, 1'b1, 32'h1, 1'b0, 0, 0, 1'b0)));
    vecs.push_back(mk("srl_0", EXE_SRL_OP, EXE_RES_SHIFT, 32'h0, 32'hDEADBEEF, 5'd12, 1'b1, 0, 0,
                      outs(5'd12, 1'b1, 32'hDEADBEEF, 1'b0, 0, 0, 1'b0)));
    vecs.push_back(mk("and", EXE_AND_OP, EXE_RES_LOGIC, 32'hF0F0F0F0, 32'hFF00FF00, 5'd13, 1'b1, 0, 0,
                      outs(5'd13, 1'b1, 32'hF000F000, 1'b0, 0, 0, 1'b0)));
    vecs.push_back(mk("lui_or", EXE_OR_OP, EXE_RES_LOGIC, 32'h0, 32'h12340000, 5'd14, 1'b1, 0, 0,
                      outs(5'd14, 1'b1, 32'h12340000, 1'b0, 0, 0, 1'b0)));
    vecs.push_back(mk("xor", EXE_XOR_OP, EXE_RES_LOGIC, 32'hAAAA5555, 32'hFFFF0000, 5'd15, 1'b1, 0, 0,
                      outs(5'd15, 1'b1, 32'h55555555, 1'b0, 0, 0, 1'b0)));
    vecs.push_back(mk("nor", EXE_NOR_OP, EXE_RES_LOGIC, 32'h0F0F0000, 32'h00000F0F, 5'd16, 1'b1, 0, 0,
                      outs(5'd16, 1'b1, 32'hF0F0F0F0, 1'b0, 0, 0, 1'b0)));
    vecs.push_back(mk("mfhi", EXE_MFHI_OP, EXE_RES_MOVE, 0, 0, 5'd2, 1'b1, 32'h11112222, 32'h33334444,
                      outs(5'd2, 1'b1, 32'h11112222, 1'b0, 0, 0, 1'b0)));
    vecs.push_back(mk("mflo", EXE_MFLO_OP, EXE_RES_MOVE, 0, 0, 5'd2, 1'b1, 32'h11112222, 32'h33334444,
                      outs(5'd2, 1'b1, 32'h33334444, 1'b0, 0, 0, 1'b0)));
    vecs.push_back(mk("mthi", EXE_MTHI_OP, EXE_RES_MOVE, 32'hABCD0000, 0, 5'd0, 1'b0, 32'h1, 32'h2,
                      outs(5'd0, 1'b0, 32'h0, 1'b1, 32'hABCD0000, 32'h2, 1'b0)));
    vecs.push_back(mk("mtlo", EXE_MTLO_OP, EXE_RES_MOVE, 32'h5, 0, 5'd0, 1'b0, 32'h7, 32'h9,
                      outs(5'd0, 1'b0, 32'h0, 1'b1, 32'h7, 32'h5, 1'b0)));
    vecs.push_back(mk("nop", EXE_NOP_OP, EXE_RES_NOP, 32'h1234, 32'h5678, 5'd9, 1'b1, 32'h1, 32'h2,
                      outs(5'd9, 1'b0, 32'h0, 1'b0, 0, 0, 1'b0)));

    // Reset asserted with live inputs: everything must read zero.
    rst = 1'b0;
    drive(EXE_ADDU_OP, EXE_RES_ARITHMETIC, 32'h1, 32'h2, 5'd5, 1'b1, 32'h0, 32'h0);
    #3;
    check("reset_outputs", actual(), outs(5'd0, 1'b0, 32'h0, 1'b0, 0, 0, 1'b0));
    drive(EXE_DIVU_OP, EXE_RES_NOP, 32'd100, 32'd7, 5'd5, 1'b1, 32'h0, 32'h0);
    @(negedge clk);
    check("reset_div_quiet", actual(), outs(5'd0, 1'b0, 32'h0, 1'b0, 0, 0, 1'b0));
    tick();
    rst = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].op, vecs[i].sel, vecs[i].r1, vecs[i].r2, vecs[i].wd, vecs[i].wreg,
            vecs[i].hi, vecs[i].lo);
      @(negedge clk);
      check(vecs[i].name, actual(), vecs[i].exp);
      tick();
    end

    run_div("divu_100_7", EXE_DIVU_OP, 32'd100, 32'd7, 32'd2, 32'd14, 34);
    nop_check("divu_single_pulse");
    run_div("div_m7_2", EXE_DIV_OP, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 34);
    run_div("div_7_m2", EXE_DIV_OP, 32'd7, 32'hFFFFFFFE, 32'h1, 32'hFFFFFFFD, 34);
    run_div("div_min_m1", EXE_DIV_OP, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 34);
    run_div("divu_big", EXE_DIVU_OP, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h1, 32'h1, 34);
    run_div("divu_by1", EXE_DIVU_OP, 32'hFFFFFFFF, 32'h1, 32'h0, 32'hFFFFFFFF, 34);
    run_div("div_by0", EXE_DIV_OP, 32'd123, 32'd0, 32'h0, 32'h0, 3);
    nop_check("div_by0_single_pulse");
    run_div("b2b_9_3", EXE_DIVU_OP, 32'd9, 32'd3, 32'h0, 32'h3, 34);
    run_div("b2b_10_3", EXE_DIVU_OP, 32'd10, 32'd3, 32'h1, 32'h3, 34);
    nop_check("b2b_idle");

    // Abort a divide part-way through, then confirm a fresh divide is clean.
    drive(EXE_DIVU_OP, EXE_RES_NOP, 32'd1000, 32'd3, 5'd7, 1'b1, 32'h0, 32'h0);
    for (int k = 0; k < 11; k++) tick();
    @(negedge clk);
    check("mid_div_stall", 104'(stallreq_o), 104'd1);
    #2;
    rst = 1'b0;
    #1;
    check("mid_div_reset", actual(), outs(5'd0, 1'b0, 32'h0, 1'b0, 0, 0, 1'b0));
    tick();
    tick();
    rst = 1'b1;
    run_div("post_reset_divu", EXE_DIVU_OP, 32'd50, 32'd5, 32'h0, 32'd10, 34);
    nop_check("post_reset_idle");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
